sat_cntr_prog: RTL and testbench

- Programmable, parametrised up/down counter.
- Mode-selectable limit behaviour: saturate, wrap, or one-shot halt.
- Runtime lower/upper limits, variable step size, synchronous load/clear, registered limit-event pulse.
- Used as the general-purpose timing/event counter in datapath and control blocks; replaces fixed-range saturating counters.

---
 rtl/sat_cntr_prog.sv | 137 +++++++++++++
 tb/tb_sat_cntr_prog.sv | 241 ++++++++++++++++++++++++
 2 files changed

// File: rtl/sat_cntr_prog.sv
// rtl/sat_cntr_prog.sv - programmable up/down counter with saturate, wrap and one-shot limit modes
//
// Purpose: general-purpose timing/event counter. Runtime lower/upper limits,
// variable step, synchronous clear/load, registered limit-event pulse.
// Optional macro SAT_CNTR_PRESCALE_EN adds a prescaler (presc port) that
// gates count steps to one every presc+1 qualified enable cycles.
//
// Ports:
//   clk          rising-edge clock
//   n_reset      asynchronous active-low reset
//   clr          synchronous clear: Q <= lo, clears done
//   load         synchronous load of load_val clamped to [lo,hi], clears done
//   load_val     load value
//   en           count enable
//   up           1 = count up, 0 = count down
//   mode         00 saturate, 01 wrap, 10 one-shot, 11 saturate
//   step         unsigned step magnitude
//   lo, hi       unsigned lower/upper limits
//   presc        prescaler terminal value (SAT_CNTR_PRESCALE_EN only)
//   Q            registered counter value
//   at_hi, at_lo combinational Q == hi / Q == lo
//   limit_pulse  registered one-cycle pulse after a step hit or crossed a limit
//   done         registered, high while halted in one-shot mode
//   cfg_err      combinational lo > hi
module sat_cntr_prog #(
  parameter int N          = 8,
  parameter int STEP_W     = 4,
  parameter int PRESCALE_W = 4
) (
  input  logic                  clk,
  input  logic                  n_reset,
  input  logic                  clr,
  input  logic                  load,
  input  logic [N-1:0]          load_val,
  input  logic                  en,
  input  logic                  up,
  input  logic [1:0]            mode,
  input  logic [STEP_W-1:0]     step,
  input  logic [N-1:0]          lo,
  input  logic [N-1:0]          hi,
`ifdef SAT_CNTR_PRESCALE_EN
  input  logic [PRESCALE_W-1:0] presc,
`endif
  output logic [N-1:0]          Q,
  output logic                  at_hi,
  output logic                  at_lo,
  output logic                  limit_pulse,
  output logic                  done,
  output logic                  cfg_err
);

  localparam logic [1:0] MODE_WRAP = 2'b01;
  localparam logic [1:0] MODE_ONE  = 2'b10;

  assign cfg_err = (lo > hi);
  assign at_hi   = (Q == hi);
  assign at_lo   = (Q == lo);

  // Cycle qualifies for counting regardless of step value.
  logic qual;
  assign qual = en & ~cfg_err & ~done;

  logic presc_tick;

`ifdef SAT_CNTR_PRESCALE_EN
  logic [PRESCALE_W-1:0] pcnt;

  assign presc_tick = (pcnt == presc);

  always_ff @(posedge clk or negedge n_reset) begin
    if (!n_reset) begin
      pcnt <= '0;
    end else if (clr || load) begin
      pcnt <= '0;
    end else if (qual) begin
      pcnt <= presc_tick ? '0 : pcnt + 1'b1;
    end
  end
`else
  // No prescaler: every qualified cycle is a stepping cycle.
  assign presc_tick = (PRESCALE_W > 0);
`endif

  logic go;
  assign go = qual & presc_tick & (step != '0);

  // One extra bit: carry on the way up, borrow on the way down.
  logic [N:0] sum;
  logic [N:0] diff;
  assign sum  = {1'b0, Q} + (N+1)'(step);
  assign diff = {1'b0, Q} - (N+1)'(step);

  logic         hit;
  logic [N-1:0] nxt_q;

  always_comb begin
    hit   = 1'b0;
    nxt_q = up ? sum[N-1:0] : diff[N-1:0];
    if (up) begin
      if (sum >= {1'b0, hi}) begin
        hit   = 1'b1;
        // Only a true crossing wraps; landing exactly on hi stays at hi.
        nxt_q = ((sum > {1'b0, hi}) && (mode == MODE_WRAP)) ? lo : hi;
      end
    end else begin
      if (diff[N] || (diff[N-1:0] <= lo)) begin
        hit   = 1'b1;
        nxt_q = ((diff[N] || (diff[N-1:0] < lo)) && (mode == MODE_WRAP)) ? hi : lo;
      end
    end
  end

  always_ff @(posedge clk or negedge n_reset) begin
    if (!n_reset) begin
      Q           <= '0;
      limit_pulse <= 1'b0;
      done        <= 1'b0;
    end else if (clr) begin
      Q           <= lo;
      limit_pulse <= 1'b0;
      done        <= 1'b0;
    end else if (load) begin
      if (load_val < lo)      Q <= lo;
      else if (load_val > hi) Q <= hi;
      else                    Q <= load_val;
      limit_pulse <= 1'b0;
      done        <= 1'b0;
    end else if (go) begin
      Q           <= nxt_q;
      limit_pulse <= hit;
      if (hit && (mode == MODE_ONE)) done <= 1'b1;
    end else begin
      limit_pulse <= 1'b0;
    end
  end

endmodule

// File: tb/tb_sat_cntr_prog.sv
// tb/tb_sat_cntr_prog.sv - self-checking bench for sat_cntr_prog
module tb_sat_cntr_prog;

  localparam int N  = 8;
  localparam int SW = 4;

  logic          clk = 1'b0;
  logic          n_reset;
  logic          clr, load, en, up;
  logic [N-1:0]  load_val, lo, hi;
  logic [1:0]    mode;
  logic [SW-1:0] step;
  logic [3:0]    presc;
  logic [N-1:0]  q;
  logic          at_hi, at_lo, limit_pulse, done, cfg_err;

  sat_cntr_prog #(.N(N), .STEP_W(SW), .PRESCALE_W(4)) dut (
    .clk        (clk),
    .n_reset    (n_reset),
    .clr        (clr),
    .load       (load),
    .load_val   (load_val),
    .en         (en),
    .up         (up),
    .mode       (mode),
    .step       (step),
    .lo         (lo),
    .hi         (hi),
`ifdef SAT_CNTR_PRESCALE_EN
    .presc      (presc),
`endif
    .Q          (q),
    .at_hi      (at_hi),
    .at_lo      (at_lo),
    .limit_pulse(limit_pulse),
    .done       (done),
    .cfg_err    (cfg_err)
  );

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  // Reference state
  int m_q    = 0;
  int m_lp   = 0;
  int m_done = 0;
  int m_pre  = 0;

  // Next-state of the reference from the inputs present before the edge.
  task automatic model_edge();
    int l, h, v, t, s;
    bit qual, go;
    l = lo; h = hi; v = load_val; s = step;
    if (clr) begin
      m_q = l; m_done = 0; m_lp = 0; m_pre = 0;
    end else if (load) begin
      m_q = (v < l) ? l : ((v > h) ? h : v);
      m_done = 0; m_lp = 0; m_pre = 0;
    end else begin
      qual = en && !(l > h) && (m_done == 0);
      go   = qual && (s != 0);
`ifdef SAT_CNTR_PRESCALE_EN
      if (qual) begin
        if (m_pre == int'(presc)) m_pre = 0;
        else begin m_pre = m_pre + 1; go = 0; end
      end
`endif
      m_lp = 0;
      if (go) begin
        if (up) begin
          t = m_q + s;
          if (t >= h) begin
            m_lp = 1;
            m_q  = (t > h && mode == 2'b01) ? l : h;
            if (mode == 2'b10) m_done = 1;
          end else m_q = t;
        end else begin
          t = m_q - s;
          if (t <= l) begin
            m_lp = 1;
            m_q  = (t < l && mode == 2'b01) ? h : l;
            if (mode == 2'b10) m_done = 1;
          end else m_q = t;
        end
      end
    end
  endtask

  task automatic tick();
    model_edge();
    @(posedge clk);
    #1;
  endtask

  task automatic model_async_reset();
    m_q = 0; m_lp = 0; m_done = 0; m_pre = 0;
  endtask

  task automatic test_reset();
    n_reset = 1'b0; clr = 0; load = 0; en = 0; up = 1; mode = 0;
    step = 1; lo = 0; hi = 8'hFF; load_val = 0; presc = 0;
    #12;
    checks++; if (q !== 8'h00) begin failures++; $display("FAIL reset_q got=%0h exp=0", q); end
    checks++; if (limit_pulse !== 1'b0) begin failures++; $display("FAIL reset_lp got=%0b exp=0", limit_pulse); end
    checks++; if (done !== 1'b0) begin failures++; $display("FAIL reset_done got=%0b exp=0", done); end
    n_reset = 1'b1;
    model_async_reset();
    @(posedge clk); #1;
    load = 1; load_val = 8'h35; tick(); load = 0;
    en = 1; tick(); tick();
    checks++; if (q !== 8'h37) begin failures++; $display("FAIL precount_q got=%0h exp=37", q); end
    #2; n_reset = 1'b0; #1;
    checks++; if (q !== 8'h00) begin failures++; $display("FAIL async_reset_q got=%0h exp=0", q); end
    checks++; if (limit_pulse !== 1'b0 || done !== 1'b0) begin failures++; $display("FAIL async_reset_flags got=%0b%0b exp=00", limit_pulse, done); end
    model_async_reset();
    #2; n_reset = 1'b1;
    @(posedge clk); #1;
    en = 0; clr = 1; lo = 8'h10; tick(); clr = 0;
    checks++; if (q !== 8'h10) begin failures++; $display("FAIL clr_q got=%0h exp=10", q); end
    checks++; if (at_lo !== 1'b1) begin failures++; $display("FAIL clr_at_lo got=%0b exp=1", at_lo); end
  endtask

  task automatic test_saturate_up();
    lo = 8'h00; hi = 8'hF0; step = 7; mode = 2'b00; up = 1; en = 0;
    load = 1; load_val = 8'hEE; tick(); load = 0;
    en = 1; tick();
    checks++; if (q !== 8'hF0 || limit_pulse !== 1'b1) begin failures++; $display("FAIL sat_first got=%0h/%0b exp=f0/1", q, limit_pulse); end
    checks++; if (at_hi !== 1'b1) begin failures++; $display("FAIL sat_at_hi got=%0b exp=1", at_hi); end
    tick();
    checks++; if (q !== 8'hF0 || limit_pulse !== 1'b1) begin failures++; $display("FAIL sat_repeat got=%0h/%0b exp=f0/1", q, limit_pulse); end
    en = 0; tick();
    checks++; if (q !== 8'hF0 || limit_pulse !== 1'b0) begin failures++; $display("FAIL sat_idle got=%0h/%0b exp=f0/0", q, limit_pulse); end
  endtask

  task automatic test_wrap_down();
    lo = 8'h20; hi = 8'h80; step = 5; mode = 2'b01; up = 0; en = 0;
    load = 1; load_val = 8'h22; tick(); load = 0;
    en = 1; tick();
    checks++; if (q !== 8'h80 || limit_pulse !== 1'b1) begin failures++; $display("FAIL wrap_first got=%0h/%0b exp=80/1", q, limit_pulse); end
    tick();
    checks++; if (q !== 8'h7B || limit_pulse !== 1'b0) begin failures++; $display("FAIL wrap_next got=%0h/%0b exp=7b/0", q, limit_pulse); end
    en = 0;
  endtask

  task automatic test_one_shot();
    lo = 0; hi = 3; step = 1; mode = 2'b10; up = 1; en = 0;
    load = 1; load_val = 0; tick(); load = 0;
    en = 1;
    for (int i = 1; i <= 3; i++) begin
      tick();
      checks++; if (q !== N'(i)) begin failures++; $display("FAIL oneshot_q%0d got=%0h exp=%0h", i, q, i); end
    end
    checks++; if (done !== 1'b1 || limit_pulse !== 1'b1) begin failures++; $display("FAIL oneshot_done got=%0b/%0b exp=1/1", done, limit_pulse); end
    tick();
    checks++; if (q !== 8'h03 || done !== 1'b1 || limit_pulse !== 1'b0) begin failures++; $display("FAIL oneshot_halt got=%0h/%0b/%0b exp=3/1/0", q, done, limit_pulse); end
    mode = 2'b00; tick();
    checks++; if (done !== 1'b1 || q !== 8'h03) begin failures++; $display("FAIL oneshot_mode_chg got=%0b/%0h exp=1/3", done, q); end
    load = 1; load_val = 0; tick(); load = 0;
    checks++; if (done !== 1'b0 || q !== 8'h00) begin failures++; $display("FAIL oneshot_reload got=%0b/%0h exp=0/0", done, q); end
    en = 0;
  endtask

  task automatic test_load_clamp();
    lo = 8'h10; hi = 8'h40; en = 0; mode = 0; up = 1; step = 1;
    load = 1; load_val = 8'h90; tick();
    checks++; if (q !== 8'h40) begin failures++; $display("FAIL load_clamp_hi got=%0h exp=40", q); end
    load_val = 8'h05; tick();
    checks++; if (q !== 8'h10) begin failures++; $display("FAIL load_clamp_lo got=%0h exp=10", q); end
    load_val = 8'h25; tick();
    checks++; if (q !== 8'h25) begin failures++; $display("FAIL load_in_range got=%0h exp=25", q); end
    clr = 1; load_val = 8'h30; tick(); clr = 0; load = 0;
    checks++; if (q !== 8'h10) begin failures++; $display("FAIL clr_over_load got=%0h exp=10", q); end
    lo = 8'h50; hi = 8'h40; #1;
    checks++; if (cfg_err !== 1'b1) begin failures++; $display("FAIL cfg_err got=%0b exp=1", cfg_err); end
    en = 1; tick(); tick();
    checks++; if (q !== 8'h10 || limit_pulse !== 1'b0) begin failures++; $display("FAIL cfg_err_freeze got=%0h/%0b exp=10/0", q, limit_pulse); end
    en = 0; lo = 8'h00; hi = 8'hFF;
  endtask

`ifdef SAT_CNTR_PRESCALE_EN
  task automatic test_prescale();
    lo = 0; hi = 8'hFF; step = 1; mode = 0; up = 1; en = 0; presc = 2;
    clr = 1; tick(); clr = 0;
    en = 1;
    tick(); tick();
    checks++; if (q !== 8'h00) begin failures++; $display("FAIL presc_wait got=%0h exp=0", q); end
    tick();
    checks++; if (q !== 8'h01) begin failures++; $display("FAIL presc_step1 got=%0h exp=1", q); end
    tick(); clr = 1; tick(); clr = 0;
    tick(); tick();
    checks++; if (q !== 8'h00) begin failures++; $display("FAIL presc_phase got=%0h exp=0", q); end
    tick();
    checks++; if (q !== 8'h01) begin failures++; $display("FAIL presc_after_clr got=%0h exp=1", q); end
    en = 0; presc = 0;
  endtask
`endif

  task automatic test_random();
    for (int i = 0; i < 3000; i++) begin
      clr  = ($urandom_range(0, 31) == 0);
      load = ($urandom_range(0, 15) == 0);
      en   = ($urandom_range(0, 3) != 0);
      up   = $urandom_range(0, 1);
      mode = $urandom_range(0, 3);
      step = $urandom_range(0, 15);
      load_val = $urandom_range(0, 255);
`ifdef SAT_CNTR_PRESCALE_EN
      if ($urandom_range(0, 63) == 0) presc = $urandom_range(0, 3);
`endif
      if ($urandom_range(0, 15) == 0) begin
        lo = $urandom_range(0, 127);
        hi = ($urandom_range(0, 7) == 0) ? N'($urandom_range(0, 255))
                                         : N'(int'(lo) + $urandom_range(0, 128));
      end
      tick();
      checks++; if (q !== N'(m_q)) begin failures++; $display("FAIL rnd_q[%0d] got=%0h exp=%0h", i, q, m_q); end
      checks++; if (limit_pulse !== 1'(m_lp)) begin failures++; $display("FAIL rnd_lp[%0d] got=%0b exp=%0d", i, limit_pulse, m_lp); end
      checks++; if (done !== 1'(m_done)) begin failures++; $display("FAIL rnd_done[%0d] got=%0b exp=%0d", i, done, m_done); end
      checks++; if (at_hi !== (m_q == int'(hi)) || at_lo !== (m_q == int'(lo))) begin failures++; $display("FAIL rnd_at[%0d] got=%0b%0b", i, at_hi, at_lo); end
      checks++; if (cfg_err !== (int'(lo) > int'(hi))) begin failures++; $display("FAIL rnd_cfg[%0d] got=%0b", i, cfg_err); end
    end
    clr = 0; load = 0; en = 0;
  endtask

  initial begin
    test_reset();
    test_saturate_up();
    test_wrap_down();
    test_one_shot();
    test_load_clamp();
`ifdef SAT_CNTR_PRESCALE_EN
    test_prescale();
`endif
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
